// File: rtl/mul_div_issue_queue.sv
// ============================================================================
// Module      : mul_div_issue_queue
// Description : Shift-compacting reservation station for the mult/div unit.
//               Snoops the CDB for operand wakeup and issues the oldest ready entry.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     en_dispatch,
    input  logic                     is_div_in,
    input  logic [DATA_W-1:0]        rs1_data_in,
    input  logic [TAG_W-1:0]         rs1_tag_in,
    input  logic                     rs1_valid_in,
    input  logic [DATA_W-1:0]        rs2_data_in,
    input  logic [TAG_W-1:0]         rs2_tag_in,
    input  logic                     rs2_valid_in,
    input  logic [TAG_W-1:0]         rd_tag_in,
    output logic                     queue_full,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [DATA_W-1:0]        cdb_data,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic                     issue_is_div,
    output logic [DATA_W-1:0]        issue_rs1_data,
    output logic [DATA_W-1:0]        issue_rs2_data,
    output logic [TAG_W-1:0]         issue_rd_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic              is_div;
        logic [DATA_W-1:0] rs1_data;
        logic [TAG_W-1:0]  rs1_tag;
        logic              rs1_valid;
        logic [DATA_W-1:0] rs2_data;
        logic [TAG_W-1:0]  rs2_tag;
        logic              rs2_valid;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    entry_t             q     [DEPTH];
    entry_t             woken [DEPTH+1];
    entry_t             nxt   [DEPTH];
    entry_t             new_entry;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               do_issue;
    logic               do_enq;
    logic [CNT_W-1:0]   enq_pos;

    assign queue_full = (count == CNT_W'(DEPTH));
    assign do_issue   = sel_found & issue_ready;
    assign do_enq     = en_dispatch & ~queue_full;
    assign enq_pos    = do_issue ? (count - CNT_W'(1)) : count;

    // Oldest-first select over registered state only
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && q[i].valid && q[i].rs1_valid && q[i].rs2_valid) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        issue_valid    = sel_found;
        issue_is_div   = 1'b0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        issue_rd_tag   = '0;
        if (sel_found) begin
            issue_is_div   = q[sel_idx].is_div;
            issue_rs1_data = q[sel_idx].rs1_data;
            issue_rs2_data = q[sel_idx].rs2_data;
            issue_rd_tag   = q[sel_idx].rd_tag;
        end
    end

    // CDB wakeup of resident entries; slot DEPTH is an empty filler for the shift
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            if (q[i].valid && cdb_valid) begin
                if (!q[i].rs1_valid && (q[i].rs1_tag == cdb_tag)) begin
                    woken[i].rs1_data  = cdb_data;
                    woken[i].rs1_valid = 1'b1;
                end
                if (!q[i].rs2_valid && (q[i].rs2_tag == cdb_tag)) begin
                    woken[i].rs2_data  = cdb_data;
                    woken[i].rs2_valid = 1'b1;
                end
            end
        end
        woken[DEPTH] = '0;
    end

    // Incoming packet with dispatch-cycle CDB bypass
    always_comb begin
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.is_div    = is_div_in;
        new_entry.rs1_data  = rs1_data_in;
        new_entry.rs1_tag   = rs1_tag_in;
        new_entry.rs1_valid = rs1_valid_in;
        new_entry.rs2_data  = rs2_data_in;
        new_entry.rs2_tag   = rs2_tag_in;
        new_entry.rs2_valid = rs2_valid_in;
        new_entry.rd_tag    = rd_tag_in;
        if (cdb_valid && !rs1_valid_in && (cdb_tag == rs1_tag_in)) begin
            new_entry.rs1_data  = cdb_data;
            new_entry.rs1_valid = 1'b1;
        end
        if (cdb_valid && !rs2_valid_in && (cdb_tag == rs2_tag_in)) begin
            new_entry.rs2_data  = cdb_data;
            new_entry.rs2_valid = 1'b1;
        end
    end

    // Compaction above the issued slot, then insertion at the new tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && (CNT_W'(i) >= {1'b0, sel_idx})) begin
                nxt[i] = woken[i+1];
            end else begin
                nxt[i] = woken[i];
            end
            if (do_enq && (CNT_W'(i) == enq_pos)) begin
                nxt[i] = new_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= nxt[i];
            end
            case ({do_enq, do_issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_issue_queue.sv
// ============================================================================
// Module      : tb_mul_div_issue_queue
// Description : Directed self-checking bench for mul_div_issue_queue.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_div_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        en_dispatch;
    logic        is_div_in;
    logic [31:0] rs1_data_in;
    logic [5:0]  rs1_tag_in;
    logic        rs1_valid_in;
    logic [31:0] rs2_data_in;
    logic [5:0]  rs2_tag_in;
    logic        rs2_valid_in;
    logic [5:0]  rd_tag_in;
    logic        queue_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_is_div;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;
    logic [5:0]  issue_rd_tag;
    logic [2:0]  count;

    int vectors     = 0;
    int miscompares = 0;

    mul_div_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .en_dispatch    (en_dispatch),
        .is_div_in      (is_div_in),
        .rs1_data_in    (rs1_data_in),
        .rs1_tag_in     (rs1_tag_in),
        .rs1_valid_in   (rs1_valid_in),
        .rs2_data_in    (rs2_data_in),
        .rs2_tag_in     (rs2_tag_in),
        .rs2_valid_in   (rs2_valid_in),
        .rd_tag_in      (rd_tag_in),
        .queue_full     (queue_full),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_is_div   (issue_is_div),
        .issue_rs1_data (issue_rs1_data),
        .issue_rs2_data (issue_rs2_data),
        .issue_rd_tag   (issue_rd_tag),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_packet(input logic div, input logic [31:0] d1, input logic [5:0] t1,
                              input logic v1, input logic [31:0] d2, input logic [5:0] t2,
                              input logic v2, input logic [5:0] rd);
        en_dispatch  = 1'b1;
        is_div_in    = div;
        rs1_data_in  = d1;
        rs1_tag_in   = t1;
        rs1_valid_in = v1;
        rs2_data_in  = d2;
        rs2_tag_in   = t2;
        rs2_valid_in = v2;
        rd_tag_in    = rd;
    endtask

    task automatic dispatch_ready(input logic [31:0] d1, input logic [31:0] d2, input logic [5:0] rd);
        set_packet(1'b0, d1, 6'd0, 1'b1, d2, 6'd0, 1'b1, rd);
        tick();
        en_dispatch = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; en_dispatch = 1'b0; is_div_in = 1'b0;
        rs1_data_in = '0; rs1_tag_in = '0; rs1_valid_in = 1'b0;
        rs2_data_in = '0; rs2_tag_in = '0; rs2_valid_in = 1'b0; rd_tag_in = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
        tick(); tick();
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0 || queue_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d issue_valid=%0b full=%0b expected 0/0/0", count, issue_valid, queue_full);
        end
        vectors++;
        if (issue_rs1_data !== 32'd0 || issue_rs2_data !== 32'd0 || issue_rd_tag !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_fields: rs1=%0h rs2=%0h rd=%0d expected 0", issue_rs1_data, issue_rs2_data, issue_rd_tag);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_issue();
        issue_ready = 1'b1;
        dispatch_ready(32'd5, 32'd7, 6'd3);
        vectors++;
        if (issue_valid !== 1'b1 || issue_rs1_data !== 32'd5 || issue_rs2_data !== 32'd7 ||
            issue_rd_tag !== 6'd3 || issue_is_div !== 1'b0 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL basic_issue: v=%0b rs1=%0d rs2=%0d rd=%0d div=%0b cnt=%0d expected 1/5/7/3/0/1",
                     issue_valid, issue_rs1_data, issue_rs2_data, issue_rd_tag, issue_is_div, count);
        end
        tick();
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: count=%0d v=%0b expected 0/0", count, issue_valid);
        end
    endtask

    task automatic test_wakeup();
        int early;
        issue_ready = 1'b1;
        set_packet(1'b1, 32'd10, 6'd0, 1'b1, 32'd0, 6'd9, 1'b0, 6'd5);
        tick();
        en_dispatch = 1'b0;
        early = 0;
        for (int k = 0; k < 3; k++) begin
            if (issue_valid !== 1'b0) early++;
            tick();
        end
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd2;
        #1;
        if (issue_valid !== 1'b0) early++;
        vectors++;
        if (early != 0 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL wakeup_wait: early_valid_cycles=%0d count=%0d expected 0/1", early, count);
        end
        tick();
        cdb_valid = 1'b0;
        vectors++;
        if (issue_valid !== 1'b1 || issue_rs1_data !== 32'd10 || issue_rs2_data !== 32'd2 ||
            issue_is_div !== 1'b1 || issue_rd_tag !== 6'd5) begin
            miscompares++;
            $display("FAIL wakeup_issue: v=%0b rs1=%0d rs2=%0d div=%0b rd=%0d expected 1/10/2/1/5",
                     issue_valid, issue_rs1_data, issue_rs2_data, issue_is_div, issue_rd_tag);
        end
        tick();
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL wakeup_drain: count=%0d expected 0", count);
        end
    endtask

    task automatic test_full();
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) dispatch_ready(32'(100 + k), 32'(200 + k), 6'(20 + k));
        vectors++;
        if (queue_full !== 1'b1 || count !== 3'd4 || issue_rd_tag !== 6'd20) begin
            miscompares++;
            $display("FAIL full_state: full=%0b count=%0d rd=%0d expected 1/4/20", queue_full, count, issue_rd_tag);
        end
        dispatch_ready(32'd999, 32'd999, 6'd24);
        vectors++;
        if (count !== 3'd4 || queue_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drop: count=%0d full=%0b expected 4/1", count, queue_full);
        end
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (issue_valid !== 1'b1 || issue_rd_tag !== 6'(20 + k) || issue_rs1_data !== 32'(100 + k)) begin
                miscompares++;
                $display("FAIL full_order%0d: v=%0b rd=%0d rs1=%0d expected 1/%0d/%0d",
                         k, issue_valid, issue_rd_tag, issue_rs1_data, 20 + k, 100 + k);
            end
            tick();
        end
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain: count=%0d v=%0b expected 0/0", count, issue_valid);
        end
    endtask

    task automatic test_out_of_order();
        issue_ready = 1'b0;
        set_packet(1'b0, 32'd0, 6'd12, 1'b0, 32'd3, 6'd0, 1'b1, 6'd30);
        tick();
        dispatch_ready(32'd40, 32'd41, 6'd31);
        vectors++;
        if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd31 || issue_rs1_data !== 32'd40) begin
            miscompares++;
            $display("FAIL ooo_select: v=%0b rd=%0d rs1=%0d expected 1/31/40", issue_valid, issue_rd_tag, issue_rs1_data);
        end
        issue_ready = 1'b1;
        tick();
        vectors++;
        if (count !== 3'd1 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ooo_after_issue: count=%0d v=%0b expected 1/0", count, issue_valid);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h55;
        tick();
        cdb_valid = 1'b0;
        vectors++;
        if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd30 || issue_rs1_data !== 32'h55 || issue_rs2_data !== 32'd3) begin
            miscompares++;
            $display("FAIL ooo_wake: v=%0b rd=%0d rs1=%0h rs2=%0d expected 1/30/55/3",
                     issue_valid, issue_rd_tag, issue_rs1_data, issue_rs2_data);
        end
        tick();
    endtask

    task automatic test_bypass();
        issue_ready = 1'b0;
        set_packet(1'b0, 32'd0, 6'd4, 1'b0, 32'd1, 6'd0, 1'b1, 6'd7);
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'hDEAD;
        tick();
        en_dispatch = 1'b0; cdb_valid = 1'b0;
        vectors++;
        if (issue_valid !== 1'b1 || issue_rs1_data !== 32'hDEAD || issue_rs2_data !== 32'd1 || issue_rd_tag !== 6'd7) begin
            miscompares++;
            $display("FAIL bypass: v=%0b rs1=%0h rs2=%0d rd=%0d expected 1/dead/1/7",
                     issue_valid, issue_rs1_data, issue_rs2_data, issue_rd_tag);
        end
        issue_ready = 1'b1;
        tick();
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL bypass_drain: count=%0d expected 0", count);
        end
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b0;
        dispatch_ready(32'd1, 32'd2, 6'd40);
        issue_ready = 1'b1;
        dispatch_ready(32'd3, 32'd4, 6'd41);
        vectors++;
        if (count !== 3'd1 || issue_valid !== 1'b1 || issue_rd_tag !== 6'd41 || issue_rs2_data !== 32'd4) begin
            miscompares++;
            $display("FAIL b2b_swap: count=%0d v=%0b rd=%0d rs2=%0d expected 1/1/41/4",
                     count, issue_valid, issue_rd_tag, issue_rs2_data);
        end
        tick();
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) dispatch_ready(32'(k), 32'(k), 6'(50 + k));
        issue_ready = 1'b1;
        dispatch_ready(32'd9, 32'd9, 6'd54);
        vectors++;
        if (count !== 3'd3 || issue_rd_tag !== 6'd51) begin
            miscompares++;
            $display("FAIL b2b_full_issue: count=%0d rd=%0d expected 3/51", count, issue_rd_tag);
        end
        tick(); tick(); tick();
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: count=%0d v=%0b expected 0/0", count, issue_valid);
        end
    endtask

    task automatic test_flush_and_reset();
        issue_ready = 1'b0;
        set_packet(1'b0, 32'd0, 6'd60, 1'b0, 32'd1, 6'd0, 1'b1, 6'd61);
        tick();
        tick();
        dispatch_ready(32'd8, 32'd8, 6'd62);
        vectors++;
        if (count !== 3'd3 || issue_rd_tag !== 6'd62) begin
            miscompares++;
            $display("FAIL flush_setup: count=%0d rd=%0d expected 3/62", count, issue_rd_tag);
        end
        flush = 1'b1; issue_ready = 1'b1;
        dispatch_ready(32'd5, 32'd5, 6'd63);
        flush = 1'b0;
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0 || queue_full !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: count=%0d v=%0b full=%0b expected 0/0/0", count, issue_valid, queue_full);
        end
        issue_ready = 1'b0;
        dispatch_ready(32'd77, 32'd78, 6'd13);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0 || issue_rs1_data !== 32'd0 || issue_rd_tag !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d v=%0b rs1=%0d rd=%0d expected 0/0/0/0",
                     count, issue_valid, issue_rs1_data, issue_rd_tag);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_out_of_order();
        test_bypass();
        test_back_to_back();
        test_flush_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
